// File: rtl/audio_record_buffer.sv
// Record/playback sample buffer: captures deserializer words into a
// single-port memory and replays them in order on request.
module audio_record_buffer #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  record_start_i,
    input  logic                  play_start_i,
    input  logic                  stop_i,
    input  logic                  word_valid_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic                  play_req_i,
    output logic [DATA_WIDTH-1:0] play_data_o,
    output logic                  play_valid_o,
    output logic                  play_done_o,
    output logic                  recording_o,
    output logic                  playing_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   length_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]        length_q, length_d;
    logic                    full_q, full_d;
    logic                    done_d;
    logic                    mem_we;
    logic                    mem_re;
    logic [DATA_WIDTH-1:0]   play_data_q;
    logic                    play_valid_q;
    logic                    play_done_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Next-state and bookkeeping for the record/play/idle controller
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        length_d  = length_q;
        full_d    = full_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // record wins over play when both arrive together
                if (record_start_i) begin
                    state_d   = RECORD;
                    wr_addr_d = '0;
                    length_d  = '0;
                    full_d    = 1'b0;
                end else if (play_start_i && (length_q != '0)) begin
                    state_d   = PLAY;
                    rd_addr_d = '0;
                end
            end
            RECORD: begin
                // a word arriving with stop is still captured
                if (word_valid_i) begin
                    mem_we    = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                    length_d  = length_q + LEN_W'(1);
                    if (length_q == LEN_W'(DEPTH - 1)) begin
                        full_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (stop_i) begin
                    state_d = IDLE;
                end
            end
            PLAY: begin
                // stop suppresses a coincident read
                if (stop_i) begin
                    state_d = IDLE;
                end else if (play_req_i) begin
                    mem_re    = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    if (LEN_W'(rd_addr_q) == (length_q - LEN_W'(1))) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            length_q     <= '0;
            full_q       <= 1'b0;
            play_data_q  <= '0;
            play_valid_q <= 1'b0;
            play_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            length_q     <= length_d;
            full_q       <= full_d;
            play_valid_q <= mem_re;
            play_done_q  <= done_d;
            if (mem_re) begin
                play_data_q <= mem[rd_addr_q];
            end
        end
    end

    // Sample memory write port; contents are intentionally not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_addr_q] <= word_i;
        end
    end

    assign play_data_o  = play_data_q;
    assign play_valid_o = play_valid_q;
    assign play_done_o  = play_done_q;
    assign recording_o  = (state_q == RECORD);
    assign playing_o    = (state_q == PLAY);
    assign full_o       = full_q;
    assign length_o     = length_q;

endmodule

// File: tb/tb_audio_record_buffer.sv
// Bench for audio_record_buffer (8-word configuration) with a queue-based
// reference model of the recorder.
module tb_audio_record_buffer;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          record_start_i, play_start_i, stop_i, word_valid_i, play_req_i;
    logic [DW-1:0] word_i;
    logic [DW-1:0] play_data_o;
    logic          play_valid_o, play_done_o, recording_o, playing_o, full_o;
    logic [AW:0]   length_o;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: mode 0 idle, 1 recording, 2 playing
    int            m_mode;
    logic [DW-1:0] m_q[$];
    logic          m_full;
    int            m_rd;
    logic          m_valid, m_done;
    logic [DW-1:0] m_data;

    always #5 clock = ~clock;

    audio_record_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .record_start_i(record_start_i), .play_start_i(play_start_i),
        .stop_i(stop_i), .word_valid_i(word_valid_i), .word_i(word_i),
        .play_req_i(play_req_i), .play_data_o(play_data_o),
        .play_valid_o(play_valid_o), .play_done_o(play_done_o),
        .recording_o(recording_o), .playing_o(playing_o),
        .full_o(full_o), .length_o(length_o)
    );

    task automatic model_edge(input bit rs, input bit ps, input bit st,
                              input bit wv, input logic [DW-1:0] w, input bit rq);
        m_valid = 1'b0;
        m_done  = 1'b0;
        case (m_mode)
            0: begin
                if (rs) begin
                    m_mode = 1; m_q.delete(); m_full = 1'b0;
                end else if (ps && m_q.size() > 0) begin
                    m_mode = 2; m_rd = 0;
                end
            end
            1: begin
                if (wv) begin
                    m_q.push_back(w);
                    if (m_q.size() == DEPTH) begin
                        m_full = 1'b1; m_mode = 0;
                    end
                end
                if (st) m_mode = 0;
            end
            default: begin
                if (st) m_mode = 0;
                else if (rq) begin
                    m_data = m_q[m_rd]; m_valid = 1'b1; m_rd++;
                    if (m_rd == m_q.size()) begin
                        m_done = 1'b1; m_mode = 0;
                    end
                end
            end
        endcase
    endtask

    // one clock with the given pulses; returns 1 time unit after the edge
    task automatic cyc(input bit rs, input bit ps, input bit st,
                       input bit wv, input logic [DW-1:0] w, input bit rq);
        record_start_i = rs; play_start_i = ps; stop_i = st;
        word_valid_i = wv; word_i = w; play_req_i = rq;
        @(posedge clock);
        model_edge(rs, ps, st, wv, w, rq);
        #1;
        record_start_i = 0; play_start_i = 0; stop_i = 0;
        word_valid_i = 0; word_i = '0; play_req_i = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, '0, 0);
    endtask

    task automatic model_reset();
        m_mode = 0; m_q.delete(); m_full = 0; m_rd = 0;
        m_valid = 0; m_done = 0; m_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        record_start_i = 0; play_start_i = 0; stop_i = 0;
        word_valid_i = 0; word_i = '0; play_req_i = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        n_cmp++;
        if ({play_valid_o, play_done_o, recording_o, playing_o, full_o} !== 5'b0 ||
            play_data_o !== 16'h0 || length_o !== 4'd0) begin
            n_err++; $display("FAIL reset_init outs=%b data=%h len=%0d exp all 0",
                {play_valid_o, play_done_o, recording_o, playing_o, full_o}, play_data_o, length_o);
        end
        cyc(1, 0, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, DW'($urandom), 0);
        n_cmp++;
        if (length_o !== 4'd5 || recording_o !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_len got %0d rec=%b exp 5 rec=1", length_o, recording_o);
        end
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({recording_o, playing_o, full_o, play_valid_o, play_done_o} !== 5'b0 ||
            length_o !== 4'd0 || play_data_o !== 16'h0) begin
            n_err++; $display("FAIL mid_record_reset outs=%b len=%0d exp 0", 
                {recording_o, playing_o, full_o, play_valid_o, play_done_o}, length_o);
        end
        @(posedge clock); #1 reset = 1'b0;
        cyc(0, 1, 0, 0, '0, 0);
        idle(1);
        n_cmp++;
        if (playing_o !== 1'b0) begin
            n_err++; $display("FAIL play_after_reset playing=%b exp 0", playing_o);
        end
    endtask

    task automatic test_record_play();
        logic [DW-1:0] words [4];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        cyc(1, 0, 0, 0, '0, 0);
        n_cmp++;
        if (recording_o !== 1'b1 || length_o !== 4'd0) begin
            n_err++; $display("FAIL rec_enter rec=%b len=%0d exp 1/0", recording_o, length_o);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, words[i], 0);
            idle(15);
        end
        cyc(0, 0, 1, 0, '0, 0);
        n_cmp++;
        if (length_o !== 4'd4 || full_o !== 1'b0 || recording_o !== 1'b0) begin
            n_err++; $display("FAIL rec4_len len=%0d full=%b rec=%b exp 4/0/0", length_o, full_o, recording_o);
        end
        cyc(0, 1, 0, 0, '0, 0);
        n_cmp++;
        if (playing_o !== 1'b1 || play_valid_o !== 1'b0) begin
            n_err++; $display("FAIL play_enter playing=%b valid=%b exp 1/0", playing_o, play_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, '0, 1);
            n_cmp++;
            if (play_valid_o !== 1'b1 || play_data_o !== words[i] ||
                play_done_o !== (i == 3) || playing_o !== (i != 3)) begin
                n_err++; $display("FAIL play4_word%0d v=%b d=%h done=%b pl=%b exp 1/%h/%b/%b",
                    i, play_valid_o, play_data_o, play_done_o, playing_o, words[i], i == 3, i != 3);
            end
            idle(2);
            n_cmp++;
            if (play_valid_o !== 1'b0 || play_data_o !== words[i]) begin
                n_err++; $display("FAIL play4_hold%0d v=%b d=%h exp 0/%h", i, play_valid_o, play_data_o, words[i]);
            end
        end
    endtask

    task automatic test_full();
        cyc(1, 0, 0, 0, '0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 1, DW'($urandom), 0);
            if (i == 7) begin
                n_cmp++;
                if (full_o !== 1'b1 || length_o !== 4'd8 || recording_o !== 1'b0) begin
                    n_err++; $display("FAIL full_at8 full=%b len=%0d rec=%b exp 1/8/0", full_o, length_o, recording_o);
                end
            end
        end
        n_cmp++;
        if (length_o !== 4'd8 || m_q.size() != 8) begin
            n_err++; $display("FAIL full_no_overwrite len=%0d exp 8", length_o);
        end
        cyc(0, 1, 0, 0, '0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0, '0, 1);
            n_cmp++;
            if (play_valid_o !== m_valid || play_data_o !== m_data || play_done_o !== m_done) begin
                n_err++; $display("FAIL full_play%0d v=%b d=%h done=%b exp %b/%h/%b",
                    i, play_valid_o, play_data_o, play_done_o, m_valid, m_data, m_done);
            end
            idle(1);
        end
    endtask

    task automatic test_stop_collide();
        cyc(1, 0, 0, 0, '0, 0);
        cyc(0, 0, 0, 1, 16'h5A5A, 0);
        cyc(0, 0, 1, 1, 16'hABCD, 0);
        n_cmp++;
        if (length_o !== 4'd2 || recording_o !== 1'b0) begin
            n_err++; $display("FAIL stop_write len=%0d rec=%b exp 2/0", length_o, recording_o);
        end
        cyc(0, 1, 0, 0, '0, 0);
        cyc(0, 0, 0, 0, '0, 1);
        cyc(0, 0, 0, 0, '0, 1);
        n_cmp++;
        if (play_data_o !== 16'hABCD || play_done_o !== 1'b1) begin
            n_err++; $display("FAIL stop_word_stored d=%h done=%b exp abcd/1", play_data_o, play_done_o);
        end
        cyc(0, 1, 0, 0, '0, 0);
        cyc(0, 0, 1, 0, '0, 1);
        n_cmp++;
        if (play_valid_o !== 1'b0 || playing_o !== 1'b0) begin
            n_err++; $display("FAIL stop_vs_req v=%b pl=%b exp 0/0", play_valid_o, playing_o);
        end
        idle(1);
        n_cmp++;
        if (play_valid_o !== 1'b0) begin
            n_err++; $display("FAIL stop_vs_req_late v=%b exp 0", play_valid_o);
        end
    endtask

    task automatic test_both_starts();
        cyc(1, 1, 0, 0, '0, 0);
        n_cmp++;
        if (recording_o !== 1'b1 || playing_o !== 1'b0 || length_o !== 4'd0) begin
            n_err++; $display("FAIL both_starts rec=%b pl=%b len=%0d exp 1/0/0", recording_o, playing_o, length_o);
        end
        cyc(0, 0, 0, 1, 16'h0F0F, 0);
        cyc(0, 0, 1, 0, '0, 0);
        cyc(0, 0, 0, 0, '0, 1);
        idle(1);
        n_cmp++;
        if (play_valid_o !== 1'b0 || playing_o !== 1'b0 || length_o !== 4'd1) begin
            n_err++; $display("FAIL req_in_idle v=%b pl=%b len=%0d exp 0/0/1", play_valid_o, playing_o, length_o);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, 0, 0, '0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, DW'($urandom), 0);
        cyc(0, 1, 0, 0, '0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0, '0, 1);
            n_cmp++;
            if (play_valid_o !== 1'b1 || play_data_o !== m_q[i] || play_done_o !== (i == 7)) begin
                n_err++; $display("FAIL b2b_word%0d v=%b d=%h done=%b exp 1/%h/%b",
                    i, play_valid_o, play_data_o, play_done_o, m_q[i], i == 7);
            end
        end
        idle(1);
        n_cmp++;
        if (play_valid_o !== 1'b0 || playing_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_after v=%b pl=%b exp 0/0", play_valid_o, playing_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            cyc(($urandom_range(19) == 0), ($urandom_range(7) == 0), ($urandom_range(29) == 0),
                ($urandom_range(2) == 0), DW'($urandom), ($urandom_range(1) == 0));
            n_cmp++;
            if (recording_o !== (m_mode == 1) || playing_o !== (m_mode == 2) ||
                full_o !== m_full || length_o !== (AW + 1)'(m_q.size()) ||
                play_valid_o !== m_valid || play_done_o !== m_done || play_data_o !== m_data) begin
                n_err++;
                $display("FAIL rnd cyc %0d got rec=%b pl=%b full=%b len=%0d v=%b done=%b d=%h exp %b/%b/%b/%0d/%b/%b/%h",
                    c, recording_o, playing_o, full_o, length_o, play_valid_o, play_done_o, play_data_o,
                    m_mode == 1, m_mode == 2, m_full, m_q.size(), m_valid, m_done, m_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_record_play();
        test_full();
        test_stop_collide();
        test_both_starts();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_record_buffer.md
# audio_record_buffer

Recording/playback buffer directly downstream of the PDM deserializer. It captures each 16-bit word presented with a one-cycle valid strobe into an internal single-port sample memory. Later, on request, it replays the stored words in order to the playback path (PWM/audio output stage). It owns the record/play/idle control state machine and the stored-length bookkeeping for the recorder.

## Interface
- ADDR_WIDTH, 10, memory address width; depth DEPTH = 2^ADDR_WIDTH words
- DATA_WIDTH, 16, sample word width; matches the deserializer word size
- clock  input  1  system clock, same domain as the deserializer
- reset  input  1  asynchronous, active-high; clears all state
- record_start_i  input  1  one-cycle pulse: begin a new recording from address 0
- play_start_i  input  1  one-cycle pulse: begin playback from address 0
- stop_i  input  1  one-cycle pulse: abort record or playback, return to IDLE
- word_valid_i  input  1  one-cycle strobe: word_i holds a new sample (deserializer done)
- word_i  input  DATA_WIDTH  sample word from the deserializer
- play_req_i  input  1  one-cycle pulse from playback stage: fetch the next stored word
- play_data_o  output  DATA_WIDTH  replayed sample; held until the next valid
- play_valid_o  output  1  one-cycle strobe: play_data_o is new
- play_done_o  output  1  one-cycle strobe coincident with the last replayed word
- recording_o  output  1  high while state = RECORD
- playing_o  output  1  high while state = PLAY
- full_o  output  1  memory filled during the last recording
- length_o  output  ADDR_WIDTH+1  number of valid stored words, 0..DEPTH

## Operation
- States: IDLE, RECORD, PLAY. Reset → IDLE.
- IDLE:
  - record_start_i → RECORD; wr_addr ← 0, length ← 0, full_o ← 0.
  - play_start_i with length > 0 → PLAY; rd_addr ← 0.
  - play_start_i with length = 0 is ignored.
  - If both start pulses arrive in the same cycle, record wins.
- RECORD:
  - word_valid_i writes word_i to mem[wr_addr], then wr_addr+1 and length+1.
  - If that write makes length = DEPTH, set full_o = 1 and go to IDLE. No wrap-around and no overwrite.
  - stop_i → IDLE. If stop_i and word_valid_i arrive together, the word is written first.
  - record_start_i and play_start_i are ignored while in RECORD.
- PLAY:
  - play_req_i reads mem[rd_addr] and increments rd_addr.
  - A request for index length-1 is the last one: the state returns to IDLE and play_done_o accompanies that word.
  - stop_i → IDLE with no further valid. If stop_i and play_req_i arrive together, stop wins and no read is issued.
  - Start pulses are ignored while in PLAY.
- word_valid_i is ignored outside RECORD. play_req_i is ignored outside PLAY; play_valid_o stays 0.
- Memory contents are not reset and persist across stop. length_o persists until the next record_start_i or reset.
- Arithmetic: length is ADDR_WIDTH+1 bits unsigned so it can hold DEPTH. Addresses are ADDR_WIDTH bits and never wrap during operation.
- Reset values: all outputs are 0, including play_data_o = 0 and length_o = 0. wr_addr and rd_addr are 0. Reset mid-operation discards the recording length; memory contents are undefined to the user.

## Timing
- Write: word_valid_i sampled at edge n. length_o and the address are updated after edge n, visible in cycle n+1.
- Full: if the write at edge n reaches DEPTH, then in cycle n+1 full_o = 1 and recording_o = 0.
- Read latency is 1 cycle: play_req_i at edge n → play_valid_o = 1 with data in cycle n+1.
- Back-to-back requests every cycle are supported at full throughput.
- Last word: play_valid_o, play_done_o = 1 and playing_o = 0 all occur in the same cycle.
- State flags change one cycle after the accepting edge: recording_o and playing_o rise in cycle n+1 after a start pulse at edge n.
- No combinational path from any input to any output.

## Test plan
- Reset mid-RECORD after 5 words → all outputs 0, length_o = 0; play_start_i is then ignored (playing_o stays 0).
- record_start, 4 words 0x1111..0x4444 spaced 16 cycles, stop → length_o = 4, full_o = 0. Then play_start and 4 play_req_i → data 0x1111, 0x2222, 0x3333, 0x4444, each 1 cycle after its request; play_done_o with 0x4444; playing_o = 0 in that cycle.
- ADDR_WIDTH = 3: record 10 words → after 8 writes full_o = 1, length_o = 8, recording_o = 0. Words 9–10 are ignored; playback returns words 1–8.
- stop_i with word_valid_i (word 0xABCD) in the same cycle → word stored, length +1, state IDLE. stop_i with play_req_i in PLAY → no play_valid_o, state IDLE.
- record_start_i and play_start_i in the same IDLE cycle → RECORD entered, length_o = 0. play_req_i in IDLE → play_valid_o stays 0.
- Continuous play_req_i on every cycle over 8 stored words → 8 consecutive play_valid_o cycles, in order, with play_done_o on the 8th.
